// File: rtl/need_level_fsm.sv
// Per-channel need levels with a shared decay prescaler; boosts raise, ticks lower.
// Optional death tracking is enabled by defining NEED_DEAD_EN.
module need_level_fsm #(
  parameter int unsigned NCH        = 3,
  parameter int unsigned LVL_W      = 3,
  parameter int unsigned MAX_LVL    = 7,
  parameter int unsigned INIT_LVL   = 4,
  parameter int unsigned CRIT_LVL   = 1,
  parameter int unsigned DECAY_CYC  = 50_000_000,
  parameter int unsigned ACCEL_DIV  = 10,
  parameter int unsigned DEAD_TICKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acelerar,
  input  logic                 test,
  input  logic [NCH-1:0]       boost,
  output logic [NCH*LVL_W-1:0] level,
  output logic [NCH-1:0]       critical,
  output logic                 tick,
  output logic                 dead
);

  localparam int unsigned CNT_W  = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
  localparam int unsigned P_NORM = DECAY_CYC;
  localparam int unsigned P_ACC  = DECAY_CYC / ACCEL_DIV;

  // Elaboration-time parameter sanity checks
  if (MAX_LVL >= (1 << LVL_W)) begin : g_bad_max
    $error("MAX_LVL does not fit in LVL_W bits");
  end
  if (INIT_LVL > MAX_LVL) begin : g_bad_init
    $error("INIT_LVL above MAX_LVL");
  end
  if (ACCEL_DIV < 1 || ACCEL_DIV > DECAY_CYC) begin : g_bad_div
    $error("ACCEL_DIV out of range");
  end
  if (DEAD_TICKS < 1) begin : g_bad_dead
    $error("DEAD_TICKS must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_m1;
  logic             tick_i;
  logic             frozen;
  logic [LVL_W-1:0] lvl_q [NCH];
  logic [LVL_W-1:0] lvl_d [NCH];

  // Active period minus one; test overrides acelerar
  always_comb begin
    period_m1 = CNT_W'(P_NORM - 1);
    if (test) begin
      period_m1 = '0;
    end else if (acelerar) begin
      period_m1 = CNT_W'(P_ACC - 1);
    end
  end

  // >= so a switch to a shorter period fires immediately
  assign tick_i = (cnt_q >= period_m1);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lvl_d[i] = lvl_q[i];
      if (!frozen) begin
        if (boost[i]) begin
          if (lvl_q[i] < LVL_W'(MAX_LVL)) begin
            lvl_d[i] = lvl_q[i] + LVL_W'(1);
          end
        end else if (tick_i) begin
          if (lvl_q[i] != '0) begin
            lvl_d[i] = lvl_q[i] - LVL_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        lvl_q[i] <= LVL_W'(INIT_LVL);
      end
    end else begin
      cnt_q <= tick_i ? '0 : cnt_q + CNT_W'(1);
      tick  <= tick_i;
      for (int i = 0; i < NCH; i++) begin
        lvl_q[i] <= lvl_d[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign level[g*LVL_W +: LVL_W] = lvl_q[g];
    assign critical[g]             = (lvl_q[g] <= LVL_W'(CRIT_LVL));
  end

`ifdef NEED_DEAD_EN
  localparam int unsigned ZC_W = $clog2(DEAD_TICKS + 1);

  logic [ZC_W-1:0] zcnt_q;
  logic [ZC_W-1:0] zcnt_d;
  logic            any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (lvl_q[i] == '0) begin
        any_zero = 1'b1;
      end
    end
  end

  // Consecutive ticks that found some channel empty, saturating at DEAD_TICKS
  always_comb begin
    zcnt_d = zcnt_q;
    if (tick_i) begin
      if (!any_zero) begin
        zcnt_d = '0;
      end else if (zcnt_q < ZC_W'(DEAD_TICKS)) begin
        zcnt_d = zcnt_q + ZC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zcnt_q <= '0;
      dead   <= 1'b0;
    end else begin
      zcnt_q <= zcnt_d;
      if (zcnt_d == ZC_W'(DEAD_TICKS)) begin
        dead <= 1'b1;
      end
    end
  end

  assign frozen = dead;
`else
  assign dead   = 1'b0;
  assign frozen = 1'b0;
`endif

endmodule

// File: doc/need_level_fsm.md
NEED_LEVEL_FSM -- requirements
Module: need_level_fsm

Interface
REQ-001 Parameter NCH, default 3: number of independent need channels (0 = hunger, 1 = energy, 2 = fun).
REQ-002 Parameter LVL_W, default 3: bit width of each channel level.
REQ-003 Parameter MAX_LVL, default 7: saturation ceiling of every level; MAX_LVL < 2^LVL_W.
REQ-004 Parameter INIT_LVL, default 4: level loaded at reset; INIT_LVL <= MAX_LVL.
REQ-005 Parameter CRIT_LVL, default 1: a level at or below this value is critical.
REQ-006 Parameter DECAY_CYC, default 50_000_000: clock cycles per decay tick in normal mode.
REQ-007 Parameter ACCEL_DIV, default 10: divisor applied to DECAY_CYC when accelerated; 1 <= ACCEL_DIV <= DECAY_CYC.
REQ-008 Parameter DEAD_TICKS, default 8: consecutive zero-ticks before death; must be >= 1.
REQ-009 clk  in  1  system clock, all state on rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 acelerar  in  1  selects decay period DECAY_CYC/ACCEL_DIV.
REQ-012 test  in  1  selects decay period of 1 cycle; overrides acelerar.
REQ-013 boost  in  NCH  per-channel feed/rest/play request, sampled every cycle.
REQ-014 level  out  NCH*LVL_W  channel i level in bits [i*LVL_W +: LVL_W], registered.
REQ-015 critical  out  NCH  bit i high while level i <= CRIT_LVL.
REQ-016 tick  out  1  one-cycle pulse, high in the cycle a decay takes effect.
REQ-017 dead  out  1  sticky death flag.

Function
REQ-018 Prescaler cnt SHALL count 0..P-1, where P = 1 if test, else DECAY_CYC/ACCEL_DIV (integer division) if acelerar, else DECAY_CYC.
REQ-019 Internal tick_i = (cnt >= P-1); on tick_i cnt SHALL clear to 0, otherwise it increments; a mode change leaving cnt >= P-1 fires a tick in that cycle.
REQ-020 On each rising edge, per channel: boost[i]=1 -> level+1, saturating at MAX_LVL; else tick_i -> level-1, saturating at 0; else hold.
REQ-021 boost SHALL have priority: a boost coincident with tick_i increments the channel, and that channel loses that decay.
REQ-022 Latency SHALL be 1 cycle from boost or tick_i to the new level value.
REQ-023 tick SHALL be the registered tick_i, aligned with the updated level.
REQ-024 critical SHALL be combinational from the level registers.
REQ-025 Held boost SHALL increment once per cycle; edge detection is the caller's job.
REQ-026 Channels SHALL be fully independent apart from the shared prescaler and dead.

Reset
REQ-027 On rst=1 at a clock edge: all levels = INIT_LVL, cnt = 0, tick = 0, dead = 0, zero counter = 0; rst overrides boost, tick_i and dead.
REQ-028 rst asserted mid-count SHALL discard the partial period; the first tick follows P cycles after release.

Configuration
REQ-029 Macro NEED_DEAD_EN defined: zero counter, up to DEAD_TICKS, increments on each tick_i where any level is 0 before update, and clears on tick_i where none is 0.
REQ-030 With NEED_DEAD_EN, dead SHALL set in the cycle the counter reaches DEAD_TICKS, then hold until rst.
REQ-031 With NEED_DEAD_EN, while dead=1 levels SHALL freeze, boosts are ignored, tick continues.
REQ-032 Without NEED_DEAD_EN, dead SHALL be constant 0 and no zero-counter logic is present.

Verification (NCH=3, LVL_W=3, MAX=7, INIT=4, CRIT=1, DECAY_CYC=10, ACCEL_DIV=5, DEAD_TICKS=3)
REQ-033 Reset release, idle -> tick every 10 cycles; levels 4,3,2,1,0,0; critical=111 from the third tick; levels never wrap below 0.
REQ-034 Boost ch0 for 5 cycles from 4 -> 5,6,7,7,7; boost ch1 on a tick cycle -> ch1 +1, ch0/ch2 -1.
REQ-035 acelerar=1 -> tick every 2 cycles; test=1 -> tick every cycle; raising acelerar at cnt=7 -> tick in that cycle, then every 2 cycles.
REQ-036 NEED_DEAD_EN, all levels 0, 3 further ticks -> dead=1 on the third; boost ignored; rst -> levels 4, dead 0.
REQ-037 rst asserted at cnt=6 -> next tick exactly 10 cycles after release; levels 4.
REQ-038 Without NEED_DEAD_EN, 20 ticks at level 0 -> dead stays 0 and boost still increments.
